// File: rtl/block_output_vc.sv
// NoC router output port: flit FIFO, registered val/ret link stage and stall supervision.
// Optional OUT_PARITY_EN appends an odd-parity MSB to Data_out.
module block_output_vc #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned AF_MARGIN   = 1,
    parameter int unsigned STALL_LIMIT = 16,
    localparam int unsigned ADDR_W     = $clog2(DEPTH),
`ifdef OUT_PARITY_EN
    localparam int unsigned OUT_W      = DATA_WIDTH + 1
`else
    localparam int unsigned OUT_W      = DATA_WIDTH
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] Data_in,
    input  logic                  write,
    output logic                  full,
    output logic                  almost_full,
    output logic                  ovf,
    output logic [ADDR_W:0]       count,
    output logic [OUT_W-1:0]      Data_out,
    output logic                  val,
    input  logic                  ret,
    output logic                  stall_alarm
);

    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [ADDR_W:0]    FullCnt  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]    AfCnt    = (ADDR_W + 1)'(DEPTH - AF_MARGIN);
    localparam logic [STALL_W-1:0] StallMax = STALL_W'(STALL_LIMIT);
`ifdef OUT_PARITY_EN
    localparam logic [OUT_W-1:0]   DataRst  = {1'b1, {DATA_WIDTH{1'b0}}};
`else
    localparam logic [OUT_W-1:0]   DataRst  = '0;
`endif

    typedef enum logic {StIdle, StValid} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]       wptr_q, rptr_q;
    logic [ADDR_W:0]         count_q, count_d;
    logic [OUT_W-1:0]        data_q, data_d;
    logic                    ovf_q;
    logic [STALL_W-1:0]      stall_q, stall_d;
    logic                    alarm_q, alarm_d;
    logic                    push, pop;
    logic [DATA_WIDTH-1:0]   head;

    assign full        = (count_q == FullCnt);
    assign almost_full = (count_q >= AfCnt);
    assign ovf         = ovf_q;
    assign count       = count_q;
    assign Data_out    = data_q;
    assign val         = (state_q == StValid);
    assign stall_alarm = alarm_q;

    // Full is judged at cycle start; a same-cycle pop does not free a slot for the writer.
    assign push = write && !full;
    assign head = mem[rptr_q];

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = StValid;
                end
            end
            StValid: begin
                if (!ret) begin
                    if (count_q != '0) pop = 1'b1;
                    else               state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;

`ifdef OUT_PARITY_EN
        data_d = pop ? {~^head, head} : data_q;
`else
        data_d = pop ? head : data_q;
`endif

        if (!val || !ret)           stall_d = '0;
        else if (stall_q == StallMax) stall_d = stall_q;
        else                        stall_d = stall_q + 1'b1;
        alarm_d = alarm_q || (stall_d == StallMax);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= Data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            data_q  <= DataRst;
            ovf_q   <= 1'b0;
            stall_q <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            ovf_q   <= write && full;
            stall_q <= stall_d;
            alarm_q <= alarm_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_block_output_vc.sv
// Scoreboard bench for block_output_vc: accepted flits are queued, link transfers are compared.
module tb_block_output_vc;

`ifdef OUT_PARITY_EN
    localparam int OW = 9;
`else
    localparam int OW = 8;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    Data_in;
    logic          write;
    logic          full, almost_full, ovf, val, ret, stall_alarm;
    logic [2:0]    count;
    logic [OW-1:0] Data_out;

    int n_err = 0;
    int n_chk = 0;
    logic [OW-1:0] sb_q[$];

    block_output_vc dut (
        .clk        (clk),
        .rst        (rst),
        .Data_in    (Data_in),
        .write      (write),
        .full       (full),
        .almost_full(almost_full),
        .ovf        (ovf),
        .count      (count),
        .Data_out   (Data_out),
        .val        (val),
        .ret        (ret),
        .stall_alarm(stall_alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] exp_out(input logic [7:0] d);
`ifdef OUT_PARITY_EN
        return {~^d, d};
`else
        return d;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Link monitor: a flit leaves whenever val=1 and ret=0 ahead of a clock edge.
    always @(negedge clk) begin
        if (!rst && val && !ret) begin
            if (sb_q.size() == 0) check("sb_unexpected_flit", 32'(Data_out), 32'hFFFF_FFFF);
            else                  check("link_data", 32'(Data_out), 32'(sb_q.pop_front()));
        end
    end

    initial begin
        logic [2:0] exp_cnt [6];
        exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        rst = 1'b1; write = 1'b0; ret = 1'b0; Data_in = 8'h00;
        step(); step();
        rst = 1'b0;

        // 1: reset state held through idle cycles
        repeat (5) step();
        check("rst_val", 32'(val), 0);
        check("rst_full", 32'(full), 0);
        check("rst_af", 32'(almost_full), 0);
        check("rst_count", 32'(count), 0);
        check("rst_data", 32'(Data_out), 32'(exp_out(8'h00)));
        check("rst_alarm", 32'(stall_alarm), 0);
        check("rst_ovf", 32'(ovf), 0);

        // 2: single flit latency
        Data_in = 8'hA5; write = 1'b1; sb_q.push_back(exp_out(8'hA5));
        step();
        write = 1'b0;
        check("lat_count_k", 32'(count), 1);
        check("lat_val_k", 32'(val), 0);
        step();
        check("lat_val_k1", 32'(val), 1);
        check("lat_data_k1", 32'(Data_out), 32'(exp_out(8'hA5)));
        check("lat_count_k1", 32'(count), 0);
        step();
        check("lat_val_k2", 32'(val), 0);

        // 3: fill under backpressure, sixth flit dropped
        ret = 1'b1;
        for (int i = 0; i < 6; i++) begin
            Data_in = 8'(i + 1); write = 1'b1;
            if (i < 5) sb_q.push_back(exp_out(8'(i + 1)));
            step();
            check("fill_count", 32'(count), 32'(exp_cnt[i]));
            check("fill_full", 32'(full), 32'(exp_cnt[i] == 3'd4));
            check("fill_af", 32'(almost_full), 32'(exp_cnt[i] >= 3'd3));
            check("fill_ovf", 32'(ovf), 32'(i == 5));
        end
        write = 1'b0;
        check("fill_val", 32'(val), 1);
        check("fill_head", 32'(Data_out), 32'(exp_out(8'h01)));
        step();
        check("ovf_pulse_end", 32'(ovf), 0);
        check("hold_data", 32'(Data_out), 32'(exp_out(8'h01)));

        // 4: drain back-to-back
        ret = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_val", 32'(val), 1);
            check("drain_data", 32'(Data_out), 32'(exp_out(8'(i + 2))));
        end
        step();
        check("drain_val_end", 32'(val), 0);
        check("drain_count", 32'(count), 0);
        check("drain_sb", 32'(sb_q.size()), 0);

        // 5: stall supervision
        ret = 1'b1; Data_in = 8'h3C; write = 1'b1; sb_q.push_back(exp_out(8'h3C));
        step();
        write = 1'b0;
        step();
        check("stall_val", 32'(val), 1);
        for (int i = 0; i < 15; i++) step();
        check("stall_pre_alarm", 32'(stall_alarm), 0);
        step();
        check("stall_alarm_set", 32'(stall_alarm), 1);
        ret = 1'b0;
        repeat (3) step();
        check("stall_alarm_sticky", 32'(stall_alarm), 1);
        check("stall_val_drop", 32'(val), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("stall_alarm_rst", 32'(stall_alarm), 0);

        // 6: parity-bearing flits, then reset in the middle of a burst
        foreach (exp_cnt[i]) if (i < 2) begin
            Data_in = (i == 0) ? 8'h00 : 8'h07; write = 1'b1;
            sb_q.push_back(exp_out(Data_in));
            step();
        end
        write = 1'b0;
        repeat (4) step();
        check("par_sb", 32'(sb_q.size()), 0);
        ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Data_in = 8'(8'h11 * (i + 1)); write = 1'b1;
            step();
        end
        write = 1'b0;
        check("burst_val", 32'(val), 1);
        rst = 1'b1;
        sb_q.delete();
        step();
        rst = 1'b0; ret = 1'b0;
        check("midrst_val", 32'(val), 0);
        check("midrst_count", 32'(count), 0);
        check("midrst_full", 32'(full), 0);
        repeat (3) step();
        check("midrst_discard", 32'(val), 0);
        check("final_sb", 32'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
